// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU command sequencer: opcodes, FSM
// state encoding and the command record carried from the handshake to the FSM.
package alu_seq_pkg;

  localparam int SEQ_DATA_W = 16;
  localparam int SEQ_REG_AW = 4;
  localparam int SEQ_OP_W   = 5;
  localparam int SEQ_REP_W  = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_CMP  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_LSH  = 4'd7;
  localparam logic [3:0] OP_RSH  = 4'd8;
  localparam logic [3:0] OP_ARSH = 4'd9;
  localparam logic [3:0] OP_CLR  = 4'd15;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_CLR   = 3'd4;

  typedef struct packed {
    logic [3:0]            op;
    logic [SEQ_REG_AW-1:0] rdest;
    logic [SEQ_REG_AW-1:0] rsrc;
    logic                  imm_s;
    logic [SEQ_DATA_W-1:0] imm;
    logic [SEQ_REP_W-1:0]  rep;
  } seq_cmd_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_ARSH;
  endfunction

endpackage

// File: rtl/alu_seq_cmd_fifo.sv
// Two-entry command FIFO placed in front of the sequencer FSM when the
// skid option is built in; cleared by the sequencer reset.
module alu_seq_cmd_fifo #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven controller that is the sole driver of RegFile_Alu.
// Build option: ALU_SEQ_SKID_EN adds a two-entry command FIFO ahead of the FSM.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int REG_AW = SEQ_REG_AW,
  parameter int OP_W   = SEQ_OP_W,
  parameter int REP_W  = SEQ_REP_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rdest,
  input  logic [REG_AW-1:0] cmd_rsrc,
  input  logic              cmd_imm_s,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [REP_W-1:0]  cmd_rep,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [4:0]        res_flags,
  output logic              res_err,
  output logic [REG_AW-1:0] rf_rdest,
  output logic [REG_AW-1:0] rf_rsrc,
  output logic              rf_en,
  output logic [DATA_W-1:0] rf_imm,
  output logic              rf_imm_s,
  output logic [OP_W-1:0]   rf_opcode,
  output logic              rf_rst_n,
  input  logic [DATA_W-1:0] rf_rdest_out,
  input  logic [4:0]        rf_flags,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // valid holds its payload until then, and ready never depends on valid.
  logic        rst_q;
  logic [2:0]  state;
  seq_cmd_t    cmd_q;
  seq_cmd_t    in_cmd;
  seq_cmd_t    src_cmd;
  logic        src_valid;
  logic        take;
  logic [DATA_W-1:0] data_q;
  logic [4:0]  flags_q;
  logic        err_q;

  assign in_cmd = '{op: cmd_op, rdest: cmd_rdest, rsrc: cmd_rsrc,
                    imm_s: cmd_imm_s, imm: cmd_imm, rep: cmd_rep};

`ifdef ALU_SEQ_SKID_EN
  logic fifo_full;
  logic fifo_empty;
  seq_cmd_t fifo_head;

  alu_seq_cmd_fifo #(.W($bits(seq_cmd_t))) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (cmd_valid && cmd_ready),
    .din   (in_cmd),
    .pop   (take),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = rst_q && !fifo_full;
  assign src_valid = !fifo_empty;
  assign src_cmd   = fifo_head;
`else
  assign cmd_ready = rst_q && (state == S_IDLE);
  assign src_valid = cmd_valid;
  assign src_cmd   = in_cmd;
`endif

  assign take = rst_q && (state == S_IDLE) && src_valid;

  // cmd_q.rep doubles as the remaining-iteration counter.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rst_q   <= 1'b0;
      state   <= S_IDLE;
      cmd_q   <= '0;
      data_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rst_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (take) begin
            cmd_q   <= src_cmd;
            data_q  <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
            if (is_alu_op(src_cmd.op)) begin
              state <= S_ISSUE;
            end else if (src_cmd.op == OP_CLR) begin
              state <= S_CLR;
            end else begin
              err_q <= 1'b1;
              state <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          flags_q <= rf_flags;
          state   <= S_CAPT;
        end
        S_CAPT: begin
          data_q <= rf_rdest_out;
          if (cmd_q.rep != '0) begin
            cmd_q.rep <= cmd_q.rep - 1'b1;
            state     <= S_ISSUE;
          end else begin
            state <= S_RESP;
          end
        end
        S_CLR: begin
          data_q  <= '0;
          flags_q <= '0;
          state   <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign res_valid = (state == S_RESP);
  assign res_data  = data_q;
  assign res_flags = flags_q;
  assign res_err   = err_q;

  assign rf_rdest  = cmd_q.rdest;
  assign rf_rsrc   = cmd_q.rsrc;
  assign rf_imm    = cmd_q.imm;
  assign rf_imm_s  = cmd_q.imm_s;
  assign rf_opcode = OP_W'(cmd_q.op);
  assign rf_en     = (state == S_ISSUE);
  // RegFile_Alu is held in reset with us, and pulsed for one cycle by CLR.
  assign rf_rst_n  = rst_q && (state != S_CLR);
  assign dbg_state = state;

endmodule
